// File: rtl/mem_arbiter.sv
// Tagged round-robin arbiter: NCH device channels share one memory query/ack/answer bus.
// Acks pass the memory's tag through; answers are routed back via a tag-to-channel table.
module mem_arbiter #(
  parameter int NCH     = 2,
  parameter int BLK_W   = 128,
  parameter int IDX_W   = 26,
  parameter int TAG_W   = 4,
  parameter int OUT_MAX = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NCH*2-1:0]     dev_qry_cmd,
  input  logic [NCH*BLK_W-1:0] dev_qry_blk,
  input  logic [NCH*IDX_W-1:0] dev_qry_idx,
  output logic [NCH*TAG_W-1:0] dev_ack,
  output logic [BLK_W-1:0]     dev_ans_blk,
  output logic [NCH*TAG_W-1:0] dev_ans_tag,
  output logic [1:0]           mem_qry_cmd,
  output logic [BLK_W-1:0]     mem_qry_blk,
  output logic [IDX_W-1:0]     mem_qry_idx,
  input  logic [TAG_W-1:0]     mem_ack,
  input  logic [BLK_W-1:0]     mem_ans_blk,
  input  logic [TAG_W-1:0]     mem_ans_tag,
  output logic                 err_stray
);

  localparam int NTAG  = 1 << TAG_W;
  localparam int CH_W  = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int CNT_W = $clog2(OUT_MAX + 1);

  typedef enum logic [0:0] {S_IDLE = 1'b0, S_ISSUE = 1'b1} state_t;

  state_t               state_r, state_n;
  logic [CH_W-1:0]      ptr_r, gch_r, pick_s;
  logic [CNT_W-1:0]     count_r;
  logic                 valid_r [NTAG];
  logic [CH_W-1:0]      tch_r   [NTAG];
  logic [1:0]           qry_cmd_r, sel_cmd_s;
  logic [BLK_W-1:0]     qry_blk_r, sel_blk_s, ans_blk_r;
  logic [IDX_W-1:0]     qry_idx_r, sel_idx_s;
  logic [NCH*TAG_W-1:0] ack_r, ack_n, ans_tag_r, ans_tag_n;
  logic                 err_r;
  logic [NCH-1:0]       req_s;
  logic                 req_any_s, grant_s, ack_s, ans_vld_s, ans_hit_s, dup_s, inc_s, dec_s;

  function automatic logic [CH_W-1:0] wrap_add(input logic [CH_W-1:0] base, input int off);
    int s;
    s = int'(base) + off;
    if (s >= NCH) s = s - NCH;
    else          s = s;
    return CH_W'(s);
  endfunction

  // Requesting channels, rotating first-hit pick from the pointer, and the picked query
  always_comb begin
    req_s     = '0;
    req_any_s = 1'b0;
    pick_s    = '0;
    sel_cmd_s = 2'd0;
    sel_blk_s = '0;
    sel_idx_s = '0;
    for (int ch = 0; ch < NCH; ch++) begin
      req_s[ch] = (dev_qry_cmd[2*ch +: 2] == 2'd1) || (dev_qry_cmd[2*ch +: 2] == 2'd2);
    end
    // Walk downwards so the lowest offset from the pointer wins
    for (int i = NCH - 1; i >= 0; i--) begin
      if (req_s[wrap_add(ptr_r, i)]) begin
        req_any_s = 1'b1;
        pick_s    = wrap_add(ptr_r, i);
      end else begin
        req_any_s = req_any_s;
        pick_s    = pick_s;
      end
    end
    for (int ch = 0; ch < NCH; ch++) begin
      if (pick_s == CH_W'(ch)) begin
        sel_cmd_s = dev_qry_cmd[2*ch +: 2];
        sel_blk_s = dev_qry_blk[BLK_W*ch +: BLK_W];
        sel_idx_s = dev_qry_idx[IDX_W*ch +: IDX_W];
      end else begin
        sel_cmd_s = sel_cmd_s;
        sel_blk_s = sel_blk_s;
        sel_idx_s = sel_idx_s;
      end
    end
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_r <= S_IDLE;
    else        state_r <= state_n;
  end

  // FSM next-state logic
  always_comb begin
    state_n = state_r;
    case (state_r)
      S_IDLE: begin
        if (grant_s) state_n = S_ISSUE;
        else         state_n = S_IDLE;
      end
      S_ISSUE: begin
        if (ack_s) state_n = S_IDLE;
        else       state_n = S_ISSUE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  // FSM outputs: grant/ack strobes, table lookups (pre-update) and per-channel pulses
  always_comb begin
    grant_s   = (state_r == S_IDLE) && req_any_s && (count_r < CNT_W'(OUT_MAX));
    ack_s     = (state_r == S_ISSUE) && (mem_ack != '0);
    ans_vld_s = (mem_ans_tag != '0);
    ans_hit_s = ans_vld_s && valid_r[mem_ans_tag];
    dup_s     = ack_s && valid_r[mem_ack];
    dec_s     = ans_hit_s;
    // A live tag answered and re-acked in one cycle stays live: the table size is unchanged
    inc_s     = ack_s && (!dup_s || (ans_hit_s && (mem_ans_tag == mem_ack)));
    ack_n     = '0;
    ans_tag_n = '0;
    for (int ch = 0; ch < NCH; ch++) begin
      if (ack_s && (gch_r == CH_W'(ch))) ack_n[TAG_W*ch +: TAG_W] = mem_ack;
      else                               ack_n[TAG_W*ch +: TAG_W] = '0;
      if (ans_hit_s && (tch_r[mem_ans_tag] == CH_W'(ch))) ans_tag_n[TAG_W*ch +: TAG_W] = mem_ans_tag;
      else                                                ans_tag_n[TAG_W*ch +: TAG_W] = '0;
    end
  end

  // Query, pointer, tag table, outstanding count and registered device-side outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_r     <= '0;
      gch_r     <= '0;
      count_r   <= '0;
      qry_cmd_r <= 2'd0;
      qry_blk_r <= '0;
      qry_idx_r <= '0;
      ack_r     <= '0;
      ans_tag_r <= '0;
      ans_blk_r <= '0;
      err_r     <= 1'b0;
      for (int t = 0; t < NTAG; t++) begin
        valid_r[t] <= 1'b0;
        tch_r[t]   <= '0;
      end
    end else begin
      if (grant_s) begin
        gch_r     <= pick_s;
        qry_cmd_r <= sel_cmd_s;
        qry_blk_r <= sel_blk_s;
        qry_idx_r <= sel_idx_s;
      end
      if (ack_s) begin
        qry_cmd_r <= 2'd0;
        ptr_r     <= wrap_add(gch_r, 1);
      end
      ack_r     <= ack_n;
      ans_tag_r <= ans_tag_n;
      if (ans_hit_s) begin
        ans_blk_r              <= mem_ans_blk;
        valid_r[mem_ans_tag]   <= 1'b0;
      end
      if (ack_s) begin
        valid_r[mem_ack] <= 1'b1;
        tch_r[mem_ack]   <= gch_r;
      end
      if ((ans_vld_s && !ans_hit_s) || dup_s) err_r <= 1'b1;
      case ({inc_s, dec_s})
        2'b10:   count_r <= count_r + CNT_W'(1);
        2'b01:   count_r <= count_r - CNT_W'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  assign dev_ack     = ack_r;
  assign dev_ans_tag = ans_tag_r;
  assign dev_ans_blk = ans_blk_r;
  assign mem_qry_cmd = qry_cmd_r;
  assign mem_qry_blk = qry_blk_r;
  assign mem_qry_idx = qry_idx_r;
  assign err_stray   = err_r;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios plus randomized traffic checked against a
// tag-table reference model that predicts every registered output one cycle ahead.
module tb_mem_arbiter;

  localparam int NCH     = 2;
  localparam int BLK_W   = 128;
  localparam int IDX_W   = 26;
  localparam int TAG_W   = 4;
  localparam int OUT_MAX = 4;
  localparam int NTAG    = 1 << TAG_W;
  localparam int AW      = NCH * TAG_W;

  logic                 clk, rst_n;
  logic [NCH*2-1:0]     dev_qry_cmd;
  logic [NCH*BLK_W-1:0] dev_qry_blk;
  logic [NCH*IDX_W-1:0] dev_qry_idx;
  logic [AW-1:0]        dev_ack, dev_ans_tag;
  logic [BLK_W-1:0]     dev_ans_blk, mem_qry_blk, mem_ans_blk;
  logic [1:0]           mem_qry_cmd;
  logic [IDX_W-1:0]     mem_qry_idx;
  logic [TAG_W-1:0]     mem_ack, mem_ans_tag;
  logic                 err_stray;

  logic [1:0]       d_cmd [NCH];
  logic [IDX_W-1:0] d_idx [NCH];
  logic [BLK_W-1:0] d_blk [NCH];

  // reference model: bus-busy flag, rr pointer, tag->channel table, predicted outputs
  bit               m_busy;
  int               m_gch, m_ptr;
  bit               m_valid [NTAG];
  int               m_ch    [NTAG];
  logic [1:0]       e_qcmd;
  logic [IDX_W-1:0] e_qidx;
  logic [BLK_W-1:0] e_qblk, e_ablk;
  logic [AW-1:0]    e_ack, e_atag;
  logic             e_err;

  int total, bad;

  mem_arbiter #(.NCH(NCH), .BLK_W(BLK_W), .IDX_W(IDX_W), .TAG_W(TAG_W), .OUT_MAX(OUT_MAX)) dut (
    .clk(clk), .rst_n(rst_n),
    .dev_qry_cmd(dev_qry_cmd), .dev_qry_blk(dev_qry_blk), .dev_qry_idx(dev_qry_idx),
    .dev_ack(dev_ack), .dev_ans_blk(dev_ans_blk), .dev_ans_tag(dev_ans_tag),
    .mem_qry_cmd(mem_qry_cmd), .mem_qry_blk(mem_qry_blk), .mem_qry_idx(mem_qry_idx),
    .mem_ack(mem_ack), .mem_ans_blk(mem_ans_blk), .mem_ans_tag(mem_ans_tag),
    .err_stray(err_stray)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    dev_qry_cmd = '0;
    dev_qry_blk = '0;
    dev_qry_idx = '0;
    for (int c = 0; c < NCH; c++) begin
      dev_qry_cmd[2*c +: 2]         = d_cmd[c];
      dev_qry_blk[BLK_W*c +: BLK_W] = d_blk[c];
      dev_qry_idx[IDX_W*c +: IDX_W] = d_idx[c];
    end
  end

  function automatic logic [BLK_W-1:0] rnd_blk();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  function automatic int model_count();
    int n;
    n = 0;
    for (int t = 1; t < NTAG; t++) if (m_valid[t]) n++;
    return n;
  endfunction

  task automatic model_clear();
    m_busy = 1'b0; m_gch = 0; m_ptr = 0;
    for (int t = 0; t < NTAG; t++) begin m_valid[t] = 1'b0; m_ch[t] = 0; end
    e_qcmd = 2'd0; e_qidx = '0; e_qblk = '0; e_ack = '0; e_atag = '0; e_ablk = '0; e_err = 1'b0;
    for (int c = 0; c < NCH; c++) d_cmd[c] = 2'd0;
    mem_ack = '0; mem_ans_tag = '0; mem_ans_blk = '0;
  endtask

  // predict the outputs after the next edge from current inputs, clock, then let devices drop acked requests
  task automatic step();
    int cnt, t, c;
    bit pre_dup;
    cnt = model_count();
    e_ack = '0; e_atag = '0;
    pre_dup = m_busy && (mem_ack != '0) && m_valid[mem_ack];
    t = int'(mem_ans_tag);
    if (t != 0) begin
      if (m_valid[t]) begin
        e_atag = AW'(mem_ans_tag) << (m_ch[t] * TAG_W);
        e_ablk = mem_ans_blk;
        m_valid[t] = 1'b0;
      end else begin
        e_err = 1'b1;
      end
    end
    if (m_busy) begin
      if (mem_ack != '0) begin
        if (pre_dup) e_err = 1'b1;
        m_valid[mem_ack] = 1'b1;
        m_ch[mem_ack] = m_gch;
        e_ack = AW'(mem_ack) << (m_gch * TAG_W);
        m_ptr = (m_gch + 1) % NCH;
        m_busy = 1'b0;
        e_qcmd = 2'd0;
      end
    end else if (cnt < OUT_MAX) begin
      for (int i = 0; i < NCH; i++) begin
        c = (m_ptr + i) % NCH;
        if (!m_busy && (d_cmd[c] == 2'd1 || d_cmd[c] == 2'd2)) begin
          m_busy = 1'b1; m_gch = c;
          e_qcmd = d_cmd[c]; e_qidx = d_idx[c]; e_qblk = d_blk[c];
        end
      end
    end
    @(posedge clk); #1;
    mem_ack = '0; mem_ans_tag = '0;
    for (int ch = 0; ch < NCH; ch++) if (dev_ack[TAG_W*ch +: TAG_W] != '0) d_cmd[ch] = 2'd0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_clear();
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic wait_grant(output int n);
    n = 0;
    while (mem_qry_cmd == 2'd0 && n < 6) begin step(); n++; end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    model_clear();
    for (int c = 0; c < NCH; c++) begin d_idx[c] = '0; d_blk[c] = '0; end
    #3;
    total++;
    if ({dev_ack, dev_ans_tag, mem_qry_cmd, mem_qry_idx, err_stray} !== '0) begin
      bad++; $display("FAIL reset_ctl got=%h want=0", {dev_ack, dev_ans_tag, mem_qry_cmd, mem_qry_idx, err_stray});
    end
    total++;
    if ({dev_ans_blk, mem_qry_blk} !== '0) begin
      bad++; $display("FAIL reset_blk got=%h want=0", {dev_ans_blk, mem_qry_blk});
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    step();
    total++;
    if (mem_qry_cmd !== 2'd0 || dev_ack !== '0) begin
      bad++; $display("FAIL reset_idle got cmd=%0d ack=%h want 0", mem_qry_cmd, dev_ack);
    end
  endtask

  task automatic test_single_load();
    do_reset();
    d_cmd[0] = 2'd1; d_idx[0] = 26'h123; d_blk[0] = '0;
    step();
    total++;
    if (mem_qry_cmd !== 2'd1 || mem_qry_idx !== 26'h123) begin
      bad++; $display("FAIL single_qry got cmd=%0d idx=%h want 1/123", mem_qry_cmd, mem_qry_idx);
    end
    step(); step();
    total++;
    if (mem_qry_cmd !== 2'd1 || dev_ack !== 8'h00) begin
      bad++; $display("FAIL single_hold got cmd=%0d ack=%h want 1/00", mem_qry_cmd, dev_ack);
    end
    mem_ack = 4'd5;
    step();
    total++;
    if (dev_ack !== 8'h05 || mem_qry_cmd !== 2'd0) begin
      bad++; $display("FAIL single_ack got ack=%h cmd=%0d want 05/0", dev_ack, mem_qry_cmd);
    end
    step();
    total++;
    if (dev_ack !== 8'h00) begin
      bad++; $display("FAIL single_ack_pulse got=%h want=00", dev_ack);
    end
    step(); step();
    mem_ans_tag = 4'd5; mem_ans_blk = {16{8'hAA}};
    step();
    total++;
    if (dev_ans_tag !== 8'h05 || dev_ans_blk !== {16{8'hAA}}) begin
      bad++; $display("FAIL single_ans got tag=%h blk=%h want 05/aa..", dev_ans_tag, dev_ans_blk);
    end
    step();
    total++;
    if (dev_ans_tag !== 8'h00 || dev_ans_blk !== {16{8'hAA}} || int'(dut.count_r) != 0) begin
      bad++; $display("FAIL single_done got tag=%h blk=%h cnt=%0d want 00/aa../0", dev_ans_tag, dev_ans_blk, dut.count_r);
    end
  endtask

  task automatic test_round_robin();
    int n, ch;
    logic [AW-1:0] want;
    do_reset();
    d_idx[0] = 26'h0A0; d_idx[1] = 26'h0B1;
    for (int i = 0; i < 4; i++) begin
      d_cmd[0] = 2'd1; d_cmd[1] = 2'd1;
      wait_grant(n);
      ch = i % 2;
      total++;
      if (n != 1 || mem_qry_idx !== d_idx[ch]) begin
        bad++; $display("FAIL rr_grant%0d got idx=%h wait=%0d want idx=%h wait=1", i, mem_qry_idx, n, d_idx[ch]);
      end
      mem_ack = TAG_W'(i + 1);
      if (i > 0) begin mem_ans_tag = TAG_W'(i); mem_ans_blk = rnd_blk(); end
      step();
      want = AW'(i + 1) << (ch * TAG_W);
      total++;
      if (dev_ack !== want || dev_ans_tag !== e_atag) begin
        bad++; $display("FAIL rr_ack%0d got ack=%h ans=%h want ack=%h ans=%h", i, dev_ack, dev_ans_tag, want, e_atag);
      end
    end
  endtask

  task automatic test_out_of_order();
    logic [BLK_W-1:0] b1, b2;
    do_reset();
    d_cmd[0] = 2'd1; d_cmd[1] = 2'd1; d_idx[0] = 26'h10; d_idx[1] = 26'h20;
    step(); mem_ack = 4'd1; step();
    total++;
    if (dev_ack !== 8'h01) begin bad++; $display("FAIL ooo_ack1 got=%h want=01", dev_ack); end
    step(); mem_ack = 4'd2; step();
    total++;
    if (dev_ack !== 8'h20) begin bad++; $display("FAIL ooo_ack2 got=%h want=20", dev_ack); end
    b1 = rnd_blk(); b2 = rnd_blk();
    mem_ans_tag = 4'd2; mem_ans_blk = b2;
    step();
    total++;
    if (dev_ans_tag !== 8'h20 || dev_ans_blk !== b2) begin
      bad++; $display("FAIL ooo_ans2 got tag=%h blk=%h want 20/%h", dev_ans_tag, dev_ans_blk, b2);
    end
    mem_ans_tag = 4'd1; mem_ans_blk = b1;
    step();
    total++;
    if (dev_ans_tag !== 8'h01 || dev_ans_blk !== b1 || err_stray !== 1'b0) begin
      bad++; $display("FAIL ooo_ans1 got tag=%h blk=%h err=%b want 01/%h/0", dev_ans_tag, dev_ans_blk, err_stray, b1);
    end
  endtask

  task automatic test_out_limit();
    int n;
    do_reset();
    d_idx[0] = 26'h111; d_idx[1] = 26'h222;
    for (int i = 0; i < OUT_MAX; i++) begin
      d_cmd[0] = 2'd1; d_cmd[1] = 2'd1;
      wait_grant(n);
      mem_ack = TAG_W'(i + 1);
      step();
    end
    d_cmd[0] = 2'd1; d_cmd[1] = 2'd1;
    for (int i = 0; i < 4; i++) begin
      step();
      total++;
      if (mem_qry_cmd !== 2'd0) begin bad++; $display("FAIL lim_block%0d got cmd=%0d want 0", i, mem_qry_cmd); end
    end
    mem_ans_tag = 4'd1; mem_ans_blk = rnd_blk();
    step();
    total++;
    if (mem_qry_cmd !== 2'd0 || dev_ans_tag !== 8'h01) begin
      bad++; $display("FAIL lim_answer got cmd=%0d ans=%h want 0/01", mem_qry_cmd, dev_ans_tag);
    end
    step();
    total++;
    if (mem_qry_cmd !== 2'd1 || mem_qry_idx !== 26'h111 || mem_qry_cmd !== e_qcmd) begin
      bad++; $display("FAIL lim_release got cmd=%0d idx=%h want 1/111", mem_qry_cmd, mem_qry_idx);
    end
  endtask

  task automatic test_stray_dup();
    do_reset();
    mem_ans_tag = 4'd7; mem_ans_blk = rnd_blk();
    step();
    total++;
    if (dev_ans_tag !== 8'h00 || err_stray !== 1'b1 || dev_ans_blk !== '0) begin
      bad++; $display("FAIL stray_drop got tag=%h err=%b blk=%h want 00/1/0", dev_ans_tag, err_stray, dev_ans_blk);
    end
    step(); step();
    total++;
    if (err_stray !== 1'b1) begin bad++; $display("FAIL stray_sticky got=%b want=1", err_stray); end
    do_reset();
    total++;
    if (err_stray !== 1'b0) begin bad++; $display("FAIL stray_clear got=%b want=0", err_stray); end
    d_cmd[0] = 2'd1;
    step(); mem_ack = 4'd3; step();
    d_cmd[0] = 2'd1; d_cmd[1] = 2'd2;
    step(); mem_ack = 4'd3; step();
    total++;
    if (dev_ack !== 8'h30 || err_stray !== 1'b1 || int'(dut.count_r) != 1) begin
      bad++; $display("FAIL dup_ack got ack=%h err=%b cnt=%0d want 30/1/1", dev_ack, err_stray, dut.count_r);
    end
    mem_ans_tag = 4'd3; mem_ans_blk = rnd_blk();
    step();
    total++;
    if (dev_ans_tag !== 8'h30 || int'(dut.count_r) != 0) begin
      bad++; $display("FAIL dup_route got ans=%h cnt=%0d want 30/0", dev_ans_tag, dut.count_r);
    end
  endtask

  task automatic test_reset_mid();
    int n;
    do_reset();
    d_idx[0] = 26'h0C0; d_idx[1] = 26'h0D1;
    for (int i = 0; i < 3; i++) begin
      d_cmd[0] = 2'd1; d_cmd[1] = 2'd1;
      wait_grant(n);
      mem_ack = TAG_W'(i + 1);
      step();
    end
    d_cmd[0] = 2'd1; d_cmd[1] = 2'd1;
    wait_grant(n);
    rst_n = 1'b0;
    #2;
    total++;
    if ({dev_ack, dev_ans_tag, mem_qry_cmd, mem_qry_idx, err_stray} !== '0 || mem_qry_blk !== '0 || int'(dut.count_r) != 0) begin
      bad++; $display("FAIL mid_reset got=%h cnt=%0d want 0", {dev_ack, dev_ans_tag, mem_qry_cmd, mem_qry_idx, err_stray}, dut.count_r);
    end
    model_clear();
    @(posedge clk); #1;
    rst_n = 1'b1;
    mem_ans_tag = 4'd2; mem_ans_blk = rnd_blk();
    step();
    total++;
    if (err_stray !== 1'b1 || dev_ans_tag !== 8'h00) begin
      bad++; $display("FAIL mid_old_ans got err=%b ans=%h want 1/00", err_stray, dev_ans_tag);
    end
    d_cmd[0] = 2'd1; d_cmd[1] = 2'd1;
    step();
    total++;
    if (mem_qry_cmd !== 2'd1 || mem_qry_idx !== 26'h0C0) begin
      bad++; $display("FAIL mid_regrant got cmd=%0d idx=%h want 1/0c0", mem_qry_cmd, mem_qry_idx);
    end
    mem_ack = 4'd4;
    step();
    total++;
    if (dev_ack !== 8'h04) begin bad++; $display("FAIL mid_ack got=%h want=04", dev_ack); end
  endtask

  task automatic test_random();
    int t, k;
    int q[$];
    do_reset();
    repeat (400) begin
      for (int c = 0; c < NCH; c++) begin
        if (d_cmd[c] == 2'd0 && $urandom_range(0, 2) == 0) begin
          d_cmd[c] = 2'($urandom_range(1, 2));
          d_idx[c] = IDX_W'($urandom);
          d_blk[c] = rnd_blk();
        end
      end
      if (mem_qry_cmd != 2'd0 && $urandom_range(0, 1) == 1) begin
        t = int'($urandom_range(1, NTAG - 1)); k = 0;
        while (m_valid[t] && k < 40) begin t = int'($urandom_range(1, NTAG - 1)); k++; end
        if (!m_valid[t]) mem_ack = TAG_W'(t);
      end
      if ($urandom_range(0, 2) == 0) begin
        q.delete();
        for (int i = 1; i < NTAG; i++) if (m_valid[i]) q.push_back(i);
        if (q.size() > 0) begin
          mem_ans_tag = TAG_W'(q[$urandom_range(0, q.size() - 1)]);
          mem_ans_blk = rnd_blk();
        end
      end
      step();
      total++;
      if ({mem_qry_cmd, mem_qry_idx, mem_qry_blk} !== {e_qcmd, e_qidx, e_qblk}) begin
        bad++; $display("FAIL rnd_qry got cmd=%0d idx=%h want cmd=%0d idx=%h", mem_qry_cmd, mem_qry_idx, e_qcmd, e_qidx);
      end
      total++;
      if ({dev_ack, dev_ans_tag} !== {e_ack, e_atag}) begin
        bad++; $display("FAIL rnd_tags got ack=%h ans=%h want ack=%h ans=%h", dev_ack, dev_ans_tag, e_ack, e_atag);
      end
      total++;
      if (dev_ans_blk !== e_ablk || err_stray !== e_err) begin
        bad++; $display("FAIL rnd_ans got blk=%h err=%b want blk=%h err=%b", dev_ans_blk, err_stray, e_ablk, e_err);
      end
      total++;
      if (int'(dut.count_r) != model_count()) begin
        bad++; $display("FAIL rnd_count got=%0d want=%0d", dut.count_r, model_count());
      end
    end
  endtask

  initial begin
    total = 0; bad = 0;
    test_reset();
    test_single_load();
    test_round_robin();
    test_out_of_order();
    test_out_limit();
    test_stray_dup();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
